// File: rtl/axi_cdc_isolate_gate_pkg.sv
// Shared types for the CDC isolation gate: gate FSM states, a default AXI
// request/response struct pair and the counter-width helper.
package axi_cdc_isolate_gate_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } gate_state_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
    } gate_ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } gate_w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } gate_b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } gate_r_chan_t;

    typedef struct packed {
        gate_ax_chan_t aw;
        logic          aw_valid;
        gate_w_chan_t  w;
        logic          w_valid;
        logic          b_ready;
        gate_ax_chan_t ar;
        logic          ar_valid;
        logic          r_ready;
    } gate_axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        gate_b_chan_t b;
        logic         b_valid;
        gate_r_chan_t r;
        logic         r_valid;
    } gate_axi_resp_t;

    // Bits needed to hold 0..max_cnt inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Saturating up/down outstanding-transaction counter with full/empty flags and
// the address-channel valid-stability lock.
module axi_txn_counter
    import axi_cdc_isolate_gate_pkg::*;
#(
    parameter  int unsigned MaxCnt   = 8,
    localparam int unsigned CntWidth = cnt_width(MaxCnt)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                lock_set_i,
    input  logic                lock_clr_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                lock_o
);

    localparam logic [CntWidth-1:0] MaxVal = CntWidth'(MaxCnt);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                lock_q, lock_d;

    assign full_o  = (cnt_q == MaxVal);
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign lock_o  = lock_q;

    // Simultaneous inc/dec cancels; otherwise saturate at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (lock_clr_i) begin
            lock_d = 1'b0;
        end else if (lock_set_i) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            assert (!(inc_i && !dec_i && full_o))
                else $error("axi_txn_counter: increment while full");
            assert (!(dec_i && !inc_i && empty_o))
                else $error("axi_txn_counter: decrement while empty");
        end
    end

endmodule

// File: rtl/axi_cdc_isolate_gate.sv
// Source-domain gate in front of an AXI CDC: limits outstanding AW/AR, and on
// isolate_i drains in-flight traffic before flagging isolated_o.
module axi_cdc_isolate_gate
    import axi_cdc_isolate_gate_pkg::*;
#(
    parameter  int unsigned MaxTrans   = 8,
    parameter  type         axi_req_t  = gate_axi_req_t,
    parameter  type         axi_resp_t = gate_axi_resp_t,
    localparam int unsigned CntWidth   = cnt_width(MaxTrans)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  axi_req_t            slv_req_i,
    output axi_resp_t           slv_resp_o,
    output axi_req_t            mst_req_o,
    input  axi_resp_t           mst_resp_i,
    input  logic                isolate_i,
    output logic                isolated_o,
    output logic [CntWidth-1:0] wr_cnt_o,
    output logic [CntWidth-1:0] rd_cnt_o
);

    gate_state_e state_q;
    logic        isolated_q;

    logic wr_full, wr_empty, wr_lock;
    logic rd_full, rd_empty, rd_lock;
    logic aw_open, ar_open;
    logic aw_hs, ar_hs, b_hs, r_hs, r_last_hs;
    logic drained;

    // A locked beat stays open regardless of state or count so valid never drops.
    assign aw_open = ((state_q == NORMAL) && !wr_full) || wr_lock;
    assign ar_open = ((state_q == NORMAL) && !rd_full) || rd_lock;

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
    end

    assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_hs      = mst_resp_i.r_valid & slv_req_i.r_ready;
    assign r_last_hs = r_hs & mst_resp_i.r.last;

    axi_txn_counter #(
        .MaxCnt(MaxTrans)
    ) i_wr_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (aw_hs),
        .dec_i      (b_hs),
        .lock_set_i (mst_req_o.aw_valid & ~mst_resp_i.aw_ready),
        .lock_clr_i (aw_hs),
        .cnt_o      (wr_cnt_o),
        .full_o     (wr_full),
        .empty_o    (wr_empty),
        .lock_o     (wr_lock)
    );

    axi_txn_counter #(
        .MaxCnt(MaxTrans)
    ) i_rd_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (ar_hs),
        .dec_i      (r_last_hs),
        .lock_set_i (mst_req_o.ar_valid & ~mst_resp_i.ar_ready),
        .lock_clr_i (ar_hs),
        .cnt_o      (rd_cnt_o),
        .full_o     (rd_full),
        .empty_o    (rd_empty),
        .lock_o     (rd_lock)
    );

    assign drained = wr_empty && rd_empty && !wr_lock && !rd_lock;

    // isolated_q moves on the same edge as the state so it tracks ISOLATED exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= NORMAL;
            isolated_q <= 1'b0;
        end else begin
            if (state_q == ISOLATED) begin
                assert (!(b_hs || r_hs))
                    else $error("axi_cdc_isolate_gate: response while isolated");
            end
            case (state_q)
                NORMAL: begin
                    if (isolate_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!isolate_i) begin
                        state_q <= NORMAL;
                    end else if (drained) begin
                        state_q    <= ISOLATED;
                        isolated_q <= 1'b1;
                    end
                end
                ISOLATED: begin
                    if (!isolate_i) begin
                        state_q    <= NORMAL;
                        isolated_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= NORMAL;
                    isolated_q <= 1'b0;
                end
            endcase
        end
    end

    assign isolated_o = isolated_q;

endmodule

// File: tb/tb_axi_cdc_isolate_gate.sv
// Bench for axi_cdc_isolate_gate (MaxTrans=2): scoreboarded channel pass-through
// plus counter, gating and isolation-sequence checks.
module tb_axi_cdc_isolate_gate;
    import axi_cdc_isolate_gate_pkg::*;

    localparam int unsigned MT = 2;
    localparam int unsigned CW = cnt_width(MT);

    logic           clk = 1'b0;
    logic           rst;
    gate_axi_req_t  slv_req, mst_req;
    gate_axi_resp_t slv_resp, mst_resp;
    logic           iso, isolated;
    logic [CW-1:0]  wr_cnt, rd_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] aw_q[$], ar_q[$], w_q[$], r_q[$];
    logic [3:0]  b_q[$];

    always #5 clk = ~clk;

    axi_cdc_isolate_gate #(
        .MaxTrans   (MT),
        .axi_req_t  (gate_axi_req_t),
        .axi_resp_t (gate_axi_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .isolate_i  (iso),
        .isolated_o (isolated),
        .wr_cnt_o   (wr_cnt),
        .rd_cnt_o   (rd_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake seen on the far side must match the oldest push.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mst_req.aw_valid && mst_resp.aw_ready) begin
                if (aw_q.size() == 0) chk("aw_extra", 64'(aw_q.size()), 64'd1);
                else chk("aw_addr", 64'(mst_req.aw.addr), 64'(aw_q.pop_front()));
            end
            if (mst_req.ar_valid && mst_resp.ar_ready) begin
                if (ar_q.size() == 0) chk("ar_extra", 64'(ar_q.size()), 64'd1);
                else chk("ar_addr", 64'(mst_req.ar.addr), 64'(ar_q.pop_front()));
            end
            if (mst_req.w_valid && mst_resp.w_ready) begin
                if (w_q.size() == 0) chk("w_extra", 64'(w_q.size()), 64'd1);
                else chk("w_data", 64'(mst_req.w.data), 64'(w_q.pop_front()));
            end
            if (slv_resp.b_valid && slv_req.b_ready) begin
                if (b_q.size() == 0) chk("b_extra", 64'(b_q.size()), 64'd1);
                else chk("b_id", 64'(slv_resp.b.id), 64'(b_q.pop_front()));
            end
            if (slv_resp.r_valid && slv_req.r_ready) begin
                if (r_q.size() == 0) chk("r_extra", 64'(r_q.size()), 64'd1);
                else chk("r_data", 64'(slv_resp.r.data), 64'(r_q.pop_front()));
            end
        end
    end

    task automatic aw_send(input logic [31:0] a);
        logic hs;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = a;
        aw_q.push_back(a);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hs = slv_resp.aw_ready;
            tick();
            if (hs) begin
                slv_req.aw_valid = 1'b0;
                return;
            end
        end
        chk("aw_tmo", 64'(slv_resp.aw_ready), 64'd1);
        slv_req.aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a);
        logic hs;
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = a;
        slv_req.ar.len   = 8'd3;
        ar_q.push_back(a);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hs = slv_resp.ar_ready;
            tick();
            if (hs) begin
                slv_req.ar_valid = 1'b0;
                return;
            end
        end
        chk("ar_tmo", 64'(slv_resp.ar_ready), 64'd1);
        slv_req.ar_valid = 1'b0;
    endtask

    task automatic b_send(input logic [3:0] id);
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = id;
        slv_req.b_ready  = 1'b1;
        b_q.push_back(id);
        tick();
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
    endtask

    task automatic r_send(input logic [31:0] d, input logic last);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = d;
        mst_resp.r.last  = last;
        r_q.push_back(d);
        tick();
        mst_resp.r_valid = 1'b0;
        mst_resp.r.last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        iso      = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        slv_req.r_ready   = 1'b1;

        // reset
        tick();
        tick();
        @(negedge clk);
        chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        chk("rst_isolated", 64'(isolated), 64'd0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("idle_isolated", 64'(isolated), 64'd0);
        tick();

        // outstanding limit
        aw_send(32'h100);
        aw_send(32'h104);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h108;
        aw_q.push_back(32'h108);
        @(negedge clk);
        chk("lim_wr_cnt", 64'(wr_cnt), 64'd2);
        chk("lim_aw_rdy", 64'(slv_resp.aw_ready), 64'd0);
        chk("lim_aw_vld", 64'(mst_req.aw_valid), 64'd0);
        tick();
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = 4'd1;
        slv_req.b_ready  = 1'b1;
        b_q.push_back(4'd1);
        @(negedge clk);
        chk("lim_aw_rdy_b", 64'(slv_resp.aw_ready), 64'd0);
        tick();
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        @(negedge clk);
        chk("lim_aw_rdy_free", 64'(slv_resp.aw_ready), 64'd1);
        tick();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        chk("lim_wr_cnt_again", 64'(wr_cnt), 64'd2);
        tick();
        b_send(4'd2);
        b_send(4'd3);
        @(negedge clk);
        chk("lim_wr_cnt_zero", 64'(wr_cnt), 64'd0);
        tick();

        // simultaneous inc/dec
        aw_send(32'h200);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h204;
        aw_q.push_back(32'h204);
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = 4'd4;
        slv_req.b_ready  = 1'b1;
        b_q.push_back(4'd4);
        @(negedge clk);
        chk("sim_aw_rdy", 64'(slv_resp.aw_ready), 64'd1);
        tick();
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        @(negedge clk);
        chk("sim_wr_cnt", 64'(wr_cnt), 64'd1);
        tick();
        b_send(4'd5);
        ar_send(32'h300);
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 32'h304;
        ar_q.push_back(32'h304);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 32'hDEAD_0001;
        mst_resp.r.last  = 1'b1;
        r_q.push_back(32'hDEAD_0001);
        tick();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        mst_resp.r.last  = 1'b0;
        @(negedge clk);
        chk("sim_rd_cnt", 64'(rd_cnt), 64'd1);
        chk("sim_wr_cnt_zero", 64'(wr_cnt), 64'd0);
        tick();
        r_send(32'hDEAD_0002, 1'b1);
        @(negedge clk);
        chk("sim_rd_cnt_zero", 64'(rd_cnt), 64'd0);
        tick();

        // drain
        aw_send(32'h400);
        ar_send(32'h500);
        @(negedge clk);
        chk("drn_wr_cnt", 64'(wr_cnt), 64'd1);
        chk("drn_rd_cnt", 64'(rd_cnt), 64'd1);
        tick();
        iso = 1'b1;
        tick();
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 32'h504;
        ar_q.push_back(32'h504);
        @(negedge clk);
        chk("drn_ar_blk", 64'(slv_resp.ar_ready), 64'd0);
        chk("drn_iso_0", 64'(isolated), 64'd0);
        tick();
        b_send(4'd6);
        @(negedge clk);
        chk("drn_iso_b", 64'(isolated), 64'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            r_send(32'hBEEF_0000 + 32'(k), 1'b0);
            @(negedge clk);
            chk("drn_iso_beat", 64'(isolated), 64'd0);
            chk("drn_rd_beat", 64'(rd_cnt), 64'd1);
            tick();
        end
        r_send(32'hBEEF_0003, 1'b1);
        @(negedge clk);
        chk("drn_rd_zero", 64'(rd_cnt), 64'd0);
        chk("drn_iso_last", 64'(isolated), 64'd0);
        tick();
        @(negedge clk);
        chk("drn_isolated", 64'(isolated), 64'd1);
        chk("drn_ar_blk_iso", 64'(slv_resp.ar_ready), 64'd0);
        tick();
        slv_req.w_valid = 1'b1;
        slv_req.w.data  = 32'h5A5A_0001;
        w_q.push_back(32'h5A5A_0001);
        @(negedge clk);
        chk("iso_w_vld", 64'(mst_req.w_valid), 64'd1);
        tick();
        slv_req.w_valid = 1'b0;
        iso = 1'b0;
        tick();
        @(negedge clk);
        chk("rel_isolated", 64'(isolated), 64'd0);
        chk("rel_ar_rdy", 64'(slv_resp.ar_ready), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;
        @(negedge clk);
        chk("rel_rd_cnt", 64'(rd_cnt), 64'd1);
        tick();
        r_send(32'hBEEF_0010, 1'b1);

        // lock keeps a presented AW visible through isolation
        mst_resp.aw_ready = 1'b0;
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.addr   = 32'h600;
        aw_q.push_back(32'h600);
        tick();
        iso = 1'b1;
        tick();
        @(negedge clk);
        chk("lck_vld", 64'(mst_req.aw_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("lck_vld_hold", 64'(mst_req.aw_valid), 64'd1);
        chk("lck_iso_0", 64'(isolated), 64'd0);
        tick();
        mst_resp.aw_ready = 1'b1;
        @(negedge clk);
        chk("lck_aw_rdy", 64'(slv_resp.aw_ready), 64'd1);
        tick();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        chk("lck_wr_cnt", 64'(wr_cnt), 64'd1);
        chk("lck_iso_pend", 64'(isolated), 64'd0);
        tick();
        b_send(4'd7);
        @(negedge clk);
        chk("lck_iso_b", 64'(isolated), 64'd0);
        tick();
        @(negedge clk);
        chk("lck_isolated", 64'(isolated), 64'd1);
        tick();
        iso = 1'b0;
        tick();
        @(negedge clk);
        chk("lck_release", 64'(isolated), 64'd0);
        tick();

        // one-cycle isolate pulse
        iso = 1'b1;
        tick();
        iso = 1'b0;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h700;
        aw_q.push_back(32'h700);
        @(negedge clk);
        chk("abt_aw_blk", 64'(slv_resp.aw_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("abt_aw_rdy", 64'(slv_resp.aw_ready), 64'd1);
        chk("abt_isolated", 64'(isolated), 64'd0);
        tick();
        slv_req.aw_valid = 1'b0;
        b_send(4'd8);
        @(negedge clk);
        chk("end_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("end_rd_cnt", 64'(rd_cnt), 64'd0);
        chk("end_aw_left", 64'(aw_q.size()), 64'd0);
        chk("end_ar_left", 64'(ar_q.size()), 64'd0);
        chk("end_w_left", 64'(w_q.size()), 64'd0);
        chk("end_b_left", 64'(b_q.size()), 64'd0);
        chk("end_r_left", 64'(r_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
